rv32i_imem_loader: RTL and testbench
====================================

# rv32i_imem_loader

Byte-stream program loader and instruction memory for the rv32i pipeline core. It is the writer end of the instruction-memory interface that the core's fetch stage reads. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into a 32-entry instruction RAM. It holds the core in reset until a frame loads with a correct checksum, then releases it.

## Interface
- DEPTH, 32, instruction words stored
- AW, 5, word-address width (log2 DEPTH)
- clk  in  1  single clock, rising edge
- RN  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a load session
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- fetch_addr  in  32  word address from core NPC
- fetch_instr  out  32  instruction word at fetch_addr
- core_rst_n  out  1  active-low reset to the core
- done  out  1  last frame loaded and verified
- err  out  1  last frame rejected

## Operation
- Frame format:
  - count byte N, 1..DEPTH
  - 4·N data bytes, each word LSB first
  - one checksum byte equal to the XOR of all 4·N data bytes
- A byte is accepted on an edge where byte_valid && byte_ready.
- States and transitions:
  - IDLE: byte_ready=0. start goes to COUNT.
  - COUNT: byte_ready=1. On accept, N=0 or N>DEPTH goes to ERR. Otherwise latch N, clear the word index, byte index and checksum, and go to DATA.
  - DATA: byte_ready=1. Each accept shifts the byte into the word assembler at position byte index and XORs it into the running checksum. On the 4th byte, write the word to RAM at the word index and increment the index. After word N-1 completes, go to CSUM.
  - CSUM: byte_ready=1. On accept, a match goes to DONE and a mismatch goes to ERR.
  - DONE: byte_ready=0, done=1, core_rst_n=1.
  - ERR: byte_ready=0, err=1, core_rst_n=0.
- start handling:
  - In DONE or ERR, start goes to COUNT, clears done and err, and drives core_rst_n to 0.
  - In COUNT, DATA or CSUM, start is ignored.
- Words written before an error stay in RAM. Entries with index ≥ N keep their previous contents.
- Fetch read is combinational: fetch_instr = RAM[fetch_addr[AW-1:0]] when fetch_addr < DEPTH, else 32'h0.
- The write port is enabled only in DATA; the core has no write path.
- Reset values (asynchronous, RN=0):
  - state=IDLE, byte_ready=0, core_rst_n=0, done=0, err=0
  - all RAM entries 0, so fetch_instr=0 for every address
- Reset asserted mid-frame aborts the frame immediately with the same values. The partial word is discarded.

## Timing
- byte_ready is a registered function of state, with no combinational path from byte_valid.
- The RAM write takes effect on the edge that accepts the 4th byte of a word. fetch_instr shows the new word from the following cycle.
- A same-cycle read and write to one address returns the old word.
- done, err and core_rst_n change on the same edge that accepts the checksum byte (latency 0 after that edge).
- core_rst_n falls on the edge that accepts start in DONE or ERR.
- Minimum frame time is 4·N+2 cycles at full throughput. Gaps in byte_valid stall progress with no state loss.
- Deassertion of RN is synchronised internally (2-flop) before the FSM leaves IDLE-ready behaviour. Assertion of RN is asynchronous.

## Structure
- Package rv32i_loader_pkg holds:
  - state enum: IDLE, COUNT, DATA, CSUM, DONE, ERR
  - DEPTH and AW defaults
  - the out-of-range fetch constant 32'h0
- Sub-module rv32i_imem_ram: DEPTH×32, one synchronous write port, one asynchronous read port, cleared on RN.
- Top level holds the FSM, byte/word counters, word assembler, checksum register and reset-output logic.

## Test plan
- Reset: assert RN=0 mid-run → byte_ready=0, core_rst_n=0, done=0, err=0, fetch_instr=0 at addresses 0, 5 and 31.
- Good frame: start, then bytes 02, 00 83 20 02, 80 93 20 02, 90 at full rate → done=1, core_rst_n=1 after the 10th accept. fetch_addr 0 → 32'h02208300, 1 → 32'h02209380, 2 → 0, 40 → 0.
- Bad checksum: same frame with last byte 91 → err=1, done=0, core_rst_n=0, byte_ready=0. RAM[0]=32'h02208300 and RAM[1]=32'h02209380 are still written.
- Bad count: count byte 00, then separately 21 (33) → err=1 after one accepted byte. No RAM writes.
- Backpressure and ignored start: good frame with byte_valid low on alternate cycles, plus a start pulse during DATA → identical result to the good-frame test.
- Reset mid-frame: RN low after 3 data bytes, then a fresh start and a good 1-word frame (01, 00 06 52 00, 54) → done=1, RAM[0]=32'h00520600, RAM[1]=0.

Source files
------------

// File: rtl/rv32i_loader_pkg.sv
// Shared types and defaults for the rv32i instruction-memory loader.
package rv32i_loader_pkg;

  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned AW_DEF    = 5;

  localparam logic [31:0] FETCH_OOR = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/rv32i_imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port,
// cleared on reset. A same-cycle read of the written address sees the old word.
module rv32i_imem_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv32i_imem_loader.sv
// Framed byte-stream loader for the core's instruction RAM; holds the core in
// reset until a frame with a correct XOR checksum has been written.
module rv32i_imem_loader
  import rv32i_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic        clk,
  input  logic        RN,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_instr,
  output logic        core_rst_n,
  output logic        done,
  output logic        err
);

  // Asynchronous assertion, two-flop synchronised release.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) rst_sync <= '0;
    else     rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t        state_q, state_d;
  logic [AW:0]   count_n;
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [7:0]    csum;

  logic          accept;
  logic          count_bad;
  logic          last_word;
  logic          word_done;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  assign accept    = byte_valid && byte_ready;
  assign count_bad = (byte_data == 8'd0) || (32'(byte_data) > DEPTH);
  assign last_word = ({1'b0, word_idx} == (count_n - (AW+1)'(1)));
  assign word_done = accept && (state_q == DATA) && (byte_idx == 2'd3);
  assign wdata     = {byte_data, word_buf};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = COUNT;
      COUNT:    if (accept) state_d = count_bad ? ERR : DATA;
      DATA:     if (word_done && last_word) state_d = CSUM;
      CSUM:     if (accept) state_d = (byte_data == csum) ? DONE : ERR;
      DONE,
      ERR:      if (start) state_d = COUNT;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge
  // as the transition that causes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_ready <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_ready <= (state_d == COUNT) || (state_d == DATA) || (state_d == CSUM);
      done       <= (state_d == DONE);
      err        <= (state_d == ERR);
      core_rst_n <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_n  <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      csum     <= '0;
    end else begin
      case (state_q)
        COUNT: begin
          if (accept && !count_bad) begin
            count_n  <= byte_data[AW:0];
            word_idx <= '0;
            byte_idx <= '0;
            csum     <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            csum     <= csum ^ byte_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    word_buf[7:0]   <= byte_data;
              2'd1:    word_buf[15:8]  <= byte_data;
              2'd2:    word_buf[23:16] <= byte_data;
              default: word_idx        <= word_idx + AW'(1);
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  rv32i_imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (word_done),
    .waddr (word_idx),
    .wdata (wdata),
    .raddr (fetch_addr[AW-1:0]),
    .rdata (rdata)
  );

  assign fetch_instr = (fetch_addr < DEPTH) ? rdata : FETCH_OOR;

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Directed and randomized frame loading checked against a frame-level model.
module tb_rv32i_imem_loader;

  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        RN;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        core_rst_n;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  fr [$];

  always #5 clk = ~clk;

  rv32i_imem_loader #(
    .DEPTH (32),
    .AW    (5)
  ) dut (
    .clk         (clk),
    .RN          (RN),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .core_rst_n  (core_rst_n),
    .done        (done),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    fetch_addr = addr;
    #1;
    chk(tag, fetch_instr, exp);
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < DEPTH; a++) check_fetch($sformatf("%s_ram%0d", tag, a), a, ref_mem[a]);
    check_fetch({tag, "_oor32"}, 32'd32, 32'h0);
    check_fetch({tag, "_oor40"}, 32'd40, 32'h0);
    check_fetch({tag, "_oorrand"}, 32'd32 + $urandom_range(0, 32'h7fff_0000), 32'h0);
  endtask

  task automatic check_status(input string tag, input logic exp_done, input logic exp_err);
    chk({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_core_rst_n"}, {31'b0, core_rst_n}, {31'b0, exp_done});
    chk({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers one byte, waits (bounded) for acceptance, then idles for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_timeout", n < 50 ? 32'd1 : 32'd0, 32'd1);
    tick();
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  // Frame-level model: applies the frame's words to ref_mem, returns whether
  // it should be accepted and how many bytes the loader will consume.
  function automatic bit model_frame(input logic [7:0] f [$], output int used);
    int n;
    logic [7:0] x;
    n = int'(f[0]);
    x = 8'h00;
    if (n == 0 || n > DEPTH) begin
      used = 1;
      return 1'b0;
    end
    for (int w = 0; w < n; w++)
      ref_mem[w] = {f[4*w+4], f[4*w+3], f[4*w+2], f[4*w+1]};
    for (int i = 1; i <= 4 * n; i++) x ^= f[i];
    used = 4 * n + 2;
    return f[4*n+1] == x;
  endfunction

  // gap_mode: 0 full rate, 1 alternate cycles, 2 random gaps.
  task automatic run_frame(input string tag, input int gap_mode, input bit poke);
    int used;
    bit ok;
    ok = model_frame(fr, used);
    pulse_start();
    chk({tag, "_start_core_rst_n"}, {31'b0, core_rst_n}, 32'd0);
    chk({tag, "_start_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_start_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_start_ready"}, {31'b0, byte_ready}, 32'd1);
    for (int i = 0; i < used; i++) begin
      int gap;
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      if (i == used - 1) gap = 0;
      send_byte(fr[i], gap);
      if (poke && i == 3) pulse_start();
    end
    check_status(tag, ok, !ok);
  endtask

  task automatic apply_reset_checks(input string tag);
    chk({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'd0);
    chk({tag, "_core_rst_n"}, {31'b0, core_rst_n}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    check_fetch({tag, "_f0"}, 32'd0, 32'h0);
    check_fetch({tag, "_f5"}, 32'd5, 32'h0);
    check_fetch({tag, "_f31"}, 32'd31, 32'h0);
  endtask

  initial begin
    int n;
    int mode;
    logic [7:0] x;

    RN         = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    fetch_addr = 32'h0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 32'h0;

    #2;
    apply_reset_checks("por");
    tick();
    RN = 1'b1;
    repeat (4) tick();

    // Good frame at full rate.
    fr = {8'h02, 8'h00, 8'h83, 8'h20, 8'h02, 8'h80, 8'h93, 8'h20, 8'h02, 8'h90};
    run_frame("good", 0, 1'b0);
    check_fetch("good_w0", 32'd0, 32'h02208300);
    check_fetch("good_w1", 32'd1, 32'h02209380);
    check_fetch("good_w2", 32'd2, 32'h0);
    check_fetch("good_a40", 32'd40, 32'h0);
    check_ram("good");

    // Bad checksum: words still land in RAM.
    fr = {8'h02, 8'h00, 8'h83, 8'h20, 8'h02, 8'h80, 8'h93, 8'h20, 8'h02, 8'h91};
    run_frame("badcs", 0, 1'b0);
    check_fetch("badcs_w0", 32'd0, 32'h02208300);
    check_fetch("badcs_w1", 32'd1, 32'h02209380);
    check_ram("badcs");

    // Bad counts: rejected after a single accepted byte.
    fr = {8'h00};
    run_frame("cnt00", 0, 1'b0);
    check_ram("cnt00");
    fr = {8'h21};
    run_frame("cnt33", 0, 1'b0);
    check_ram("cnt33");

    // Backpressure with a start pulse during DATA.
    fr = {8'h02, 8'h00, 8'h83, 8'h20, 8'h02, 8'h80, 8'h93, 8'h20, 8'h02, 8'h90};
    run_frame("bp", 1, 1'b1);
    check_fetch("bp_w0", 32'd0, 32'h02208300);
    check_fetch("bp_w1", 32'd1, 32'h02209380);
    check_ram("bp");

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      mode = int'($urandom_range(0, 5));
      fr.delete();
      if (mode == 0) begin
        fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
      end else begin
        n = int'($urandom_range(1, DEPTH));
        x = 8'h00;
        fr.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          x ^= b;
          fr.push_back(b);
        end
        if (mode == 1) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
      end
      run_frame($sformatf("rnd%0d", f), int'($urandom_range(0, 2)), 1'b0);
      check_ram($sformatf("rnd%0d", f));
    end

    // Reset after three data bytes of a frame.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    RN = 1'b0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 32'h0;
    #1;
    apply_reset_checks("midrst");
    check_ram("midrst");
    tick();
    RN = 1'b1;
    repeat (4) tick();

    fr = {8'h01, 8'h00, 8'h06, 8'h52, 8'h00, 8'h54};
    run_frame("after", 0, 1'b0);
    check_fetch("after_w0", 32'd0, 32'h00520600);
    check_fetch("after_w1", 32'd1, 32'h0);
    check_ram("after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
